// File: rtl/servo_pwm_bank.sv
// Multi-channel servo pulse generator: one shared prescaler/frame counter, per-channel
// position targets with optional per-frame slew limiting, widths applied only at frame boundaries.
module servo_pwm_bank #(
    parameter int NCH         = 4,
    parameter int POS_W       = 8,
    parameter int TICK_DIV    = 195,
    parameter int FRAME_TICKS = 5129,
    parameter int MIN_TICKS   = 140,
    parameter int SCALE_SHIFT = 1,
    parameter int SLEW        = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      wr_en,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  wr_ch,
    input  logic [POS_W-1:0]                          wr_pos,
    output logic [NCH-1:0]                            servo_pulse,
    output logic                                      frame_start,
    output logic [NCH-1:0]                            settled
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WW  = $clog2(FRAME_TICKS);
    localparam int AW  = WW + POS_W + SCALE_SHIFT;
    localparam int PW  = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0] FCNT_MAX  = WW'(FRAME_TICKS - 1);
    localparam logic [AW-1:0] FMAX_A    = AW'(FRAME_TICKS - 1);
    localparam logic [AW-1:0] MIN_A     = AW'(MIN_TICKS);
    localparam logic [AW-1:0] SLEW_A    = AW'(SLEW);
    localparam logic [WW-1:0] RST_W     = (MIN_TICKS > FRAME_TICKS - 1) ? FCNT_MAX : WW'(MIN_TICKS);

    // Saturating position-to-width map; the wide sum cannot overflow before the clamp.
    function automatic logic [WW-1:0] tgt_width(input logic [POS_W-1:0] pos);
        logic [AW-1:0] sum;
        sum = MIN_A + (AW'(pos) << SCALE_SHIFT);
        if (sum > FMAX_A) begin
            tgt_width = FCNT_MAX;
        end else begin
            tgt_width = sum[WW-1:0];
        end
    endfunction

    function automatic logic [WW-1:0] slew_step(input logic [WW-1:0] cur, input logic [WW-1:0] tgt);
        logic [AW-1:0] c;
        logic [AW-1:0] t;
        logic [AW-1:0] nxt;
        c = AW'(cur);
        t = AW'(tgt);
        if (SLEW_A == '0) begin
            nxt = t;
        end else if (t > c) begin
            nxt = ((t - c) <= SLEW_A) ? t : (c + SLEW_A);
        end else begin
            nxt = ((c - t) <= SLEW_A) ? t : (c - SLEW_A);
        end
        slew_step = nxt[WW-1:0];
    endfunction

    logic [PW-1:0]    presc_q, presc_d;
    logic [WW-1:0]    fcnt_q, fcnt_d;
    logic [POS_W-1:0] tgt_pos_q [NCH];
    logic [POS_W-1:0] tgt_pos_d [NCH];
    logic [WW-1:0]    cur_w_q [NCH];
    logic [WW-1:0]    cur_w_d [NCH];
    logic [NCH-1:0]   pulse_q, pulse_d, settled_s;
    logic             frame_start_q;
    logic             tick_s, bound_s;

    // Shared timebase: prescaler and frame counter.
    always_comb begin
        tick_s  = (presc_q == PRESC_MAX);
        bound_s = tick_s && (fcnt_q == FCNT_MAX);
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1'b1);
        end
        if (bound_s) begin
            fcnt_d = '0;
        end else if (tick_s) begin
            fcnt_d = fcnt_q + WW'(1'b1);
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // Per-channel target capture, boundary width update and pulse compare against the next count.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (wr_en && (wr_ch == CHW'(i))) begin
                tgt_pos_d[i] = wr_pos;
            end else begin
                tgt_pos_d[i] = tgt_pos_q[i];
            end
            if (bound_s) begin
                cur_w_d[i] = slew_step(cur_w_q[i], tgt_width(tgt_pos_q[i]));
            end else begin
                cur_w_d[i] = cur_w_q[i];
            end
            pulse_d[i]   = (fcnt_d < cur_w_d[i]);
            settled_s[i] = (cur_w_q[i] == tgt_width(tgt_pos_q[i]));
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            fcnt_q        <= '0;
            pulse_q       <= '0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                tgt_pos_q[i] <= '0;
                cur_w_q[i]   <= RST_W;
            end
        end else begin
            presc_q       <= presc_d;
            fcnt_q        <= fcnt_d;
            pulse_q       <= pulse_d;
            frame_start_q <= bound_s;
            for (int i = 0; i < NCH; i++) begin
                tgt_pos_q[i] <= tgt_pos_d[i];
                cur_w_q[i]   <= cur_w_d[i];
            end
        end
    end

    assign servo_pulse = pulse_q;
    assign frame_start = frame_start_q;
    assign settled     = settled_s;

endmodule
